// File: rtl/vram_scan_arbiter_if.sv
// Writer and framebuffer RAM bus of the scan arbiter. The slave modport is the
// arbiter. The master modport is the environment, meaning the game-logic writer plus the RAM.
interface vram_scan_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Single-port framebuffer arbiter behind a 640x480 VGA scan.
// Display fetches come first, then the frame-synchronised clear, then the game writer.
module vram_scan_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int AW       = 15,
  parameter int DW       = 12,
  parameter int VLINES   = 480
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic [10:0]           hcount,
  input  logic [10:0]           vcount,
  input  logic                  hs_in,
  input  logic                  vs_in,
  vram_scan_arbiter_if.slave    bus,
  input  logic                  clr_start,
  input  logic [DW-1:0]         clr_color,
  output logic                  clr_busy,
  output logic                  frame_tick,
  output logic [DW-1:0]         rgb,
  output logic                  hs_o,
  output logic                  vs_o
);
  localparam int             HVIS      = FB_W << SCALE_SH;
  localparam int             FB_WORDS  = FB_W * FB_H;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(FB_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CLEAR} state_t;

  state_t        state_reg;
  logic [AW-1:0] clr_cnt_reg;
  logic [DW-1:0] clr_color_reg;
  logic          clr_busy_reg;
  logic          vis_d_reg;
  logic          fetch_d_reg;
  logic [DW-1:0] rgb_reg;
  logic          hs_reg;
  logic          vs_reg;
  logic          tick_reg;

  logic          vis;
  logic          fetch;
  logic          frame_start;
  logic [10:0]   row;
  logic [10:0]   col;
  logic [AW-1:0] fetch_addr;
  logic          wr_in_range;

  assign vis         = (hcount < 11'(HVIS)) && (vcount < 11'(VLINES));
  assign fetch       = vis && (hcount[SCALE_SH-1:0] == '0);
  assign frame_start = (hcount == 11'd0) && (vcount == 11'(VLINES));
  assign row         = vcount >> SCALE_SH;
  assign col         = hcount >> SCALE_SH;
  // row*160 as row*128 + row*32, avoiding a multiplier
  assign fetch_addr  = AW'({row, 7'b0}) + AW'({row, 5'b0}) + AW'(col);
  assign wr_in_range = bus.wr_addr < AW'(FB_WORDS);

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.wr_ack    = 1'b0;
    if (fetch) begin
      bus.ram_addr = fetch_addr;
    end else if (state_reg == CLEAR) begin
      bus.ram_addr  = clr_cnt_reg;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = clr_color_reg;
    end else if (bus.wr_req) begin
      // out-of-range writes are acknowledged but dropped so the writer never hangs
      bus.ram_addr  = bus.wr_addr;
      bus.ram_wdata = bus.wr_data;
      bus.ram_we    = wr_in_range;
      bus.wr_ack    = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= '0;
      clr_color_reg <= '0;
      clr_busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_start) begin
            state_reg     <= ARMED;
            clr_color_reg <= clr_color;
            clr_busy_reg  <= 1'b1;
          end
        end
        ARMED: begin
          if (frame_start) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
          end
        end
        CLEAR: begin
          if (!fetch) begin
            if (clr_cnt_reg == LAST_ADDR) begin
              state_reg    <= IDLE;
              clr_busy_reg <= 1'b0;
            end
            clr_cnt_reg <= clr_cnt_reg + AW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the fetch and is captured on the next edge.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vis_d_reg   <= 1'b0;
      fetch_d_reg <= 1'b0;
      rgb_reg     <= '0;
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      tick_reg    <= 1'b0;
    end else begin
      vis_d_reg   <= vis;
      fetch_d_reg <= fetch;
      hs_reg      <= hs_in;
      vs_reg      <= vs_in;
      tick_reg    <= frame_start;
      if (!vis_d_reg)
        rgb_reg <= '0;
      else if (fetch_d_reg)
        rgb_reg <= bus.ram_rdata;
    end
  end

  assign clr_busy   = clr_busy_reg;
  assign frame_tick = tick_reg;
  assign rgb        = rgb_reg;
  assign hs_o       = hs_reg;
  assign vs_o       = vs_reg;
endmodule
